i2c_txn_seq: RTL

- Hardware sequencer that drives the command interface of the existing i2c_master.
- Performs one complete register transaction per start pulse: a write of 0–4 bytes, or a read of 1–4 bytes using a repeated start. Processor software no longer issues START/WR/RD/STOP commands one at a time.
- Sits between a slot register wrapper or local FSM and i2c_master. The block drives the master's cmd/din/wr_i2c inputs and consumes its ready/ack/dout/done_tick outputs.

---
 rtl/i2c_txn_seq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_seq.sv
// Register-transaction sequencer for i2c_master: one start pulse runs a complete
// write (0-4 data bytes) or repeated-start read (1-4 bytes), from START through STOP.
module i2c_txn_seq #(
  parameter int TMO_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [2:0]  nbytes,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic [2:0]  i2c_cmd,
  output logic [7:0]  i2c_din,
  output logic        i2c_wr,
  input  logic        i2c_ready,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_dout,
  input  logic        i2c_done_tick
);
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_DATA = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {
    P_START, P_WDEV, P_WREG, P_WDATA, P_RESTART, P_RDEV, P_RD, P_STOP
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    n_q, n_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    din_q, din_d;
  logic          wr_q, wr_d;

  logic          last_byte;
  logic          nack_now;
  logic          tmo_hit;
  logic [TW-1:0] tmo_inc;
  logic [2:0]    n_clamp;

  assign last_byte = (({1'b0, idx_q} + 3'd1) == n_q);
  assign nack_now  = nack_q | (i2c_done_tick & i2c_ack);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign tmo_inc   = tmo_q + TW'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    nack_d  = nack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    wr_d    = 1'b0;

    n_clamp = (nbytes > 3'd4) ? 3'd4 : nbytes;
    if (rw && n_clamp == 3'd0) n_clamp = 3'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d    = rw;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          wdata_d = wdata;
          n_d     = n_clamp;
          idx_d   = 2'd0;
          rdata_d = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          phase_d = P_START;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        unique case (phase_q)
          P_START:   cmd_d = CMD_START;
          P_WDEV:    begin cmd_d = CMD_WR; din_d = {dev_q, 1'b0}; end
          P_WREG:    begin cmd_d = CMD_WR; din_d = reg_q; end
          P_WDATA:   begin cmd_d = CMD_WR; din_d = wdata_q[{idx_q, 3'b000} +: 8]; end
          P_RESTART: cmd_d = CMD_RESTART;
          P_RDEV:    begin cmd_d = CMD_WR; din_d = {dev_q, 1'b1}; end
          // Only the final read byte carries the NACK flag
          P_RD:      begin cmd_d = CMD_RD; din_d = {7'd0, last_byte}; end
          P_STOP:    cmd_d = CMD_STOP;
          default:   cmd_d = cmd_q;
        endcase
        if (i2c_ready) begin
          wr_d    = 1'b1;
          nack_d  = 1'b0;
          state_d = S_SETTLE;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      // The master needs a cycle to drop ready after the strobe
      S_SETTLE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i2c_done_tick) begin
          if (phase_q == P_RD) rdata_d[{idx_q, 3'b000} +: 8] = i2c_dout;
          else if (i2c_ack) nack_d = 1'b1;
        end
        if (i2c_ready) begin
          tmo_d   = '0;
          state_d = S_ISSUE;
          unique case (phase_q)
            P_START: phase_d = P_WDEV;
            P_WDEV: begin
              if (nack_now) begin err_d = ERR_ADDR; phase_d = P_STOP; end
              else phase_d = P_WREG;
            end
            P_WREG: begin
              if (nack_now)        begin err_d = ERR_DATA; phase_d = P_STOP; end
              else if (rw_q)       phase_d = P_RESTART;
              else if (n_q == 3'd0) phase_d = P_STOP;
              else                 phase_d = P_WDATA;
            end
            P_WDATA: begin
              if (nack_now)       begin err_d = ERR_DATA; phase_d = P_STOP; end
              else if (last_byte) phase_d = P_STOP;
              else                idx_d = idx_q + 2'd1;
            end
            P_RESTART: phase_d = P_RDEV;
            P_RDEV: begin
              if (nack_now) begin err_d = ERR_ADDR; phase_d = P_STOP; end
              else phase_d = P_RD;
            end
            P_RD: begin
              if (last_byte) phase_d = P_STOP;
              else           idx_d = idx_q + 2'd1;
            end
            P_STOP:  state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= P_START;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      rdata_q <= '0;
      cmd_q   <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      nack_q  <= nack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign i2c_cmd = cmd_q;
  assign i2c_din = din_q;
  assign i2c_wr  = wr_q;

endmodule
